spi_flash_status_poll: RTL and testbench

- Sequencer on the spi_drive command interface. It issues Read Status Register (RDSR, 0x05) to the SPI flash.
- It then reads status bytes back-to-back until the WIP bit (bit 0) clears or a read-count limit is reached.
- It consumes the received-byte outputs of spi_drive (data_rec/rec_done). Its completion gates the next write-enable/page-program/erase command in the flash control path.
- spi_drive is shared with the other controllers. The top level muxes spi_start/spi_end/data_send onto spi_drive while poll_busy=1.

---
 rtl/spi_flash_status_poll_if.sv | 29 ++
 rtl/spi_flash_status_poll.sv | 116 +++++++++++
 tb/tb_spi_flash_status_poll.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_status_poll_if.sv
// Command/receive handshake between the status poller and the shared spi_drive.
interface spi_flash_status_poll_if;
  logic       spi_start;
  logic       spi_end;
  logic [7:0] data_send;
  logic       send_done;
  logic       rec_done;
  logic [7:0] data_rec;

  // Sequencer side: issues transfer controls, consumes transfer results.
  modport master (
    output spi_start,
    output spi_end,
    output data_send,
    input  send_done,
    input  rec_done,
    input  data_rec
  );

  // spi_drive side.
  modport slave (
    input  spi_start,
    input  spi_end,
    input  data_send,
    output send_done,
    output rec_done,
    output data_rec
  );
endinterface

// File: rtl/spi_flash_status_poll.sv
// Polls the SPI flash status register (RDSR) until WIP clears or a byte-count bound is hit.
// The opcode phase's received byte is discarded; status bytes stream while CS stays low.
module spi_flash_status_poll #(
  parameter logic [7:0]  CMD_RDSR   = 8'h05,
  parameter logic [7:0]  DUMMY_BYTE = 8'hFF,
  parameter logic [15:0] MAX_READS  = 16'd50000
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst_n,
  input  logic                            poll_start,
  output logic                            poll_busy,
  output logic                            poll_done,
  output logic                            poll_timeout,
  output logic [7:0]                      status_byte,
  spi_flash_status_poll_if.master         spi
);

  // A bound of 0 is treated as a single read.
  localparam logic [15:0] ReadLimit = (MAX_READS == 16'd0) ? 16'd1 : MAX_READS;
  localparam logic [15:0] LastRead  = ReadLimit - 16'd1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StCmd,
    StRead,
    StEnd,
    StDone
  } state_e;

  state_e      state_q;
  logic [15:0] read_cnt_q;
  logic        timeout_q;
  logic        poll_busy_q;
  logic        poll_done_q;
  logic        poll_timeout_q;
  logic [7:0]  status_byte_q;
  logic        spi_start_q;
  logic        spi_end_q;
  logic [7:0]  data_send_q;

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q        <= StIdle;
      read_cnt_q     <= 16'd0;
      timeout_q      <= 1'b0;
      poll_busy_q    <= 1'b0;
      poll_done_q    <= 1'b0;
      poll_timeout_q <= 1'b0;
      status_byte_q  <= 8'h00;
      spi_start_q    <= 1'b0;
      spi_end_q      <= 1'b0;
      data_send_q    <= 8'h00;
    end else begin
      spi_start_q    <= 1'b0;
      spi_end_q      <= 1'b0;
      poll_done_q    <= 1'b0;
      poll_timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (poll_start) begin
            state_q     <= StStart;
            read_cnt_q  <= 16'd0;
            timeout_q   <= 1'b0;
            poll_busy_q <= 1'b1;
            spi_start_q <= 1'b1;
            data_send_q <= CMD_RDSR;
          end
        end
        StStart: state_q <= StCmd;
        StCmd: begin
          // Byte clocked in while the opcode shifts out is garbage; rec_done is ignored here.
          if (spi.send_done) begin
            data_send_q <= DUMMY_BYTE;
            state_q     <= StRead;
          end
        end
        StRead: begin
          if (spi.rec_done) begin
            status_byte_q <= spi.data_rec;
            read_cnt_q    <= read_cnt_q + 16'd1;
            if (!spi.data_rec[0]) begin
              state_q   <= StEnd;
              spi_end_q <= 1'b1;
              timeout_q <= 1'b0;
            end else if (read_cnt_q == LastRead) begin
              state_q   <= StEnd;
              spi_end_q <= 1'b1;
              timeout_q <= 1'b1;
            end
          end
        end
        StEnd: begin
          state_q        <= StDone;
          poll_done_q    <= 1'b1;
          poll_timeout_q <= timeout_q;
        end
        StDone: begin
          state_q     <= StIdle;
          poll_busy_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign poll_busy     = poll_busy_q;
  assign poll_done     = poll_done_q;
  assign poll_timeout  = poll_timeout_q;
  assign status_byte   = status_byte_q;
  assign spi.spi_start = spi_start_q;
  assign spi.spi_end   = spi_end_q;
  assign spi.data_send = data_send_q;

endmodule

// File: tb/tb_spi_flash_status_poll.sv
// Bench for spi_flash_status_poll: table-driven directed polls, random polls against a
// byte-count model, ignored restarts and an asynchronous reset in the middle of a poll.
module tb_spi_flash_status_poll;

  localparam int unsigned MaxReads = 4;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       poll_start;
  logic       poll_busy;
  logic       poll_done;
  logic       poll_timeout;
  logic [7:0] status_byte;

  spi_flash_status_poll_if sif ();

  spi_flash_status_poll #(
    .CMD_RDSR  (8'h05),
    .DUMMY_BYTE(8'hFF),
    .MAX_READS (16'(MaxReads))
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .poll_start  (poll_start),
    .poll_busy   (poll_busy),
    .poll_done   (poll_done),
    .poll_timeout(poll_timeout),
    .status_byte (status_byte),
    .spi         (sif)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_end = 0;
  int n_done = 0;

  // Pulse counters, sampled away from the active edge.
  always @(negedge sys_clk) begin
    if (sif.spi_start) n_start++;
    if (sif.spi_end) n_end++;
    if (poll_done) n_done++;
  end

  logic [7:0] seq_q[$];

  typedef struct {
    logic [7:0] seq [6];
    int         len;
    int         exp_n;
    bit         exp_to;
    logic [7:0] exp_st;
    bit         restart;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Reference: bytes consumed and timeout outcome follow from the status stream alone.
  function automatic void model(output int n, output bit to, output logic [7:0] st);
    n  = MaxReads;
    to = 1'b1;
    st = seq_q[MaxReads-1];
    for (int i = 0; i < MaxReads; i++) begin
      if (!seq_q[i][0]) begin
        n  = i + 1;
        to = 1'b0;
        st = seq_q[i];
        return;
      end
    end
  endfunction

  // Runs one poll feeding seq_q as status bytes; stops feeding once spi_end appears.
  task automatic run_poll(input string name, input int exp_n, input bit exp_to,
                          input logic [7:0] exp_st, input bit restart);
    int  s0 = n_start;
    int  e0 = n_end;
    int  d0 = n_done;
    int  n = 0;
    bit  ended = 1'b0;
    int  gaps;
    poll_start = 1'b1;
    tick();
    poll_start = 1'b0;
    check({name, " start pulse"}, 32'(sif.spi_start), 32'd1);
    check({name, " busy in start"}, 32'(poll_busy), 32'd1);
    check({name, " opcode"}, 32'(sif.data_send), 32'h05);
    tick();
    check({name, " start one cycle"}, 32'(sif.spi_start), 32'd0);
    // Random stalls in CMD, with a stray rec_done that must not touch status_byte.
    gaps = $urandom_range(0, 2);
    for (int g = 0; g < gaps; g++) begin
      sif.rec_done = 1'($urandom_range(0, 1));
      sif.data_rec = 8'($urandom);
      tick();
      sif.rec_done = 1'b0;
    end
    sif.send_done = 1'b1;
    sif.rec_done  = 1'b1;
    sif.data_rec  = 8'hFE;
    tick();
    sif.send_done = 1'b0;
    sif.rec_done  = 1'b0;
    check({name, " dummy byte"}, 32'(sif.data_send), 32'hFF);
    for (int i = 0; i < seq_q.size() && !ended; i++) begin
      gaps = (restart && i == 0) ? 1 : $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        sif.send_done = 1'($urandom_range(0, 1));
        poll_start    = (restart && i == 0 && g == 0);
        tick();
        sif.send_done = 1'b0;
        poll_start    = 1'b0;
      end
      sif.rec_done = 1'b1;
      sif.data_rec = seq_q[i];
      tick();
      sif.rec_done = 1'b0;
      n++;
      if (sif.spi_end) ended = 1'b1;
    end
    check({name, " end seen"}, 32'(ended), 32'd1);
    check({name, " bytes read"}, 32'(n), 32'(exp_n));
    tick();
    check({name, " done"}, 32'(poll_done), 32'd1);
    check({name, " timeout"}, 32'(poll_timeout), 32'(exp_to));
    check({name, " busy in done"}, 32'(poll_busy), 32'd1);
    poll_start = restart;
    tick();
    poll_start = 1'b0;
    check({name, " busy cleared"}, 32'(poll_busy), 32'd0);
    tick();
    check({name, " no restart"}, 32'(sif.spi_start), 32'd0);
    check({name, " status"}, 32'(status_byte), 32'(exp_st));
    check({name, " start count"}, 32'(n_start - s0), 32'd1);
    check({name, " end count"}, 32'(n_end - e0), 32'd1);
    check({name, " done count"}, 32'(n_done - d0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         n;
    bit         to;
    logic [7:0] st;
    int         d0;

    vecs[0] = '{seq: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, len: 1,
                exp_n: 1, exp_to: 1'b0, exp_st: 8'h00, restart: 1'b0};
    vecs[1] = '{seq: '{8'h03, 8'h03, 8'h03, 8'h02, 8'h00, 8'h00}, len: 6,
                exp_n: 4, exp_to: 1'b0, exp_st: 8'h02, restart: 1'b0};
    vecs[2] = '{seq: '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01}, len: 6,
                exp_n: 4, exp_to: 1'b1, exp_st: 8'h01, restart: 1'b0};
    vecs[3] = '{seq: '{8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00}, len: 6,
                exp_n: 2, exp_to: 1'b0, exp_st: 8'hFE, restart: 1'b0};
    vecs[4] = '{seq: '{8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 8'h01}, len: 6,
                exp_n: 4, exp_to: 1'b0, exp_st: 8'h00, restart: 1'b0};
    vecs[5] = '{seq: '{8'h81, 8'h41, 8'h20, 8'h00, 8'h00, 8'h00}, len: 6,
                exp_n: 3, exp_to: 1'b0, exp_st: 8'h20, restart: 1'b1};

    sys_rst_n     = 1'b0;
    poll_start    = 1'b0;
    sif.send_done = 1'b0;
    sif.rec_done  = 1'b0;
    sif.data_rec  = 8'h00;
    repeat (3) tick();
    check("reset busy", 32'(poll_busy), 32'd0);
    check("reset done", 32'(poll_done), 32'd0);
    check("reset timeout", 32'(poll_timeout), 32'd0);
    check("reset status", 32'(status_byte), 32'h00);
    check("reset spi_start", 32'(sif.spi_start), 32'd0);
    check("reset spi_end", 32'(sif.spi_end), 32'd0);
    check("reset data_send", 32'(sif.data_send), 32'h00);
    sys_rst_n = 1'b1;
    repeat (6) tick();
    check("idle no spi_start", 32'(n_start), 32'd0);

    for (int v = 0; v < 6; v++) begin
      seq_q = {};
      for (int i = 0; i < vecs[v].len; i++) seq_q.push_back(vecs[v].seq[i]);
      run_poll($sformatf("vec%0d", v), vecs[v].exp_n, vecs[v].exp_to, vecs[v].exp_st,
               vecs[v].restart);
    end

    for (int r = 0; r < 20; r++) begin
      seq_q = {};
      for (int i = 0; i < MaxReads + 2; i++) begin
        // Mostly-busy stream so both ready and timeout outcomes occur.
        st = 8'($urandom);
        st[0] = ($urandom_range(0, 3) != 0);
        seq_q.push_back(st);
      end
      model(n, to, st);
      run_poll($sformatf("rand%0d", r), n, to, st, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset while streaming status bytes.
    d0 = n_done;
    poll_start = 1'b1;
    tick();
    poll_start = 1'b0;
    tick();
    sif.send_done = 1'b1;
    tick();
    sif.send_done = 1'b0;
    sif.rec_done  = 1'b1;
    sif.data_rec  = 8'h03;
    tick();
    sif.rec_done = 1'b0;
    check("midreset status before", 32'(status_byte), 32'h03);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("midreset busy", 32'(poll_busy), 32'd0);
    check("midreset status", 32'(status_byte), 32'h00);
    check("midreset data_send", 32'(sif.data_send), 32'h00);
    tick();
    sys_rst_n = 1'b1;
    repeat (3) tick();
    check("midreset no done", 32'(n_done - d0), 32'd0);
    seq_q = {};
    seq_q.push_back(8'h05);
    seq_q.push_back(8'h04);
    seq_q.push_back(8'h00);
    run_poll("after reset", 2, 1'b0, 8'h04, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
